// File: rtl/arith_pkg.sv
// arith_pkg: shared op encoding and payload flag types for the arith_pipe datapath.
package arith_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 2'd0,
        OP_SUB    = 2'd1,
        OP_SEL    = 2'd2,
        OP_PASS_A = 2'd3
    } op_e;

    // Flag half of the stage payload; the data field is WIDTH-dependent and is added by the top.
    typedef struct packed {
        logic carry;
        logic sat;
    } flag_t;

endpackage

// File: rtl/arith_stage.sv
// arith_stage: one elastic register slice; accepts when empty or when downstream drains this cycle.
module arith_stage #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        in_ready = !vld_q || out_ready;
        vld_d    = in_ready ? in_valid : vld_q;
        data_d   = (in_ready && in_valid) ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;

endmodule

// File: rtl/arith_pipe.sv
// arith_pipe: pipelined add/sub/select datapath with valid/ready on both sides and monitor counters.
// Define ARITH_SAT_EN to clamp overflowing ADD to all-ones and borrowing SUB/SEL to zero.
module arith_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_sat,
    output logic [CNT_W-1:0] result_count,
    output logic [CNT_W-1:0] err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        flag_t            flags;
    } payload_t;

    localparam int PW = $bits(payload_t);

    op_e              op;
    logic [WIDTH:0]   sum, diff, raw;
    payload_t         head, tail;
    logic [STAGES:0]  vld, rdy;
    logic [PW-1:0]    pl [0:STAGES];
    logic             hs;
    logic [CNT_W-1:0] result_count_q, result_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // The extra top bit of raw is the carry for ADD and the borrow for SUB/SEL(s=1); it is 0 otherwise.
    always_comb begin
        op   = op_e'(in_op);
        sum  = {1'b0, in_a} + {1'b0, in_b};
        diff = {1'b0, in_a} - {1'b0, in_b};
        raw  = op == OP_ADD ? sum :
               (op == OP_SUB || (op == OP_SEL && in_s)) ? diff :
               op == OP_SEL ? {1'b0, in_c} : {1'b0, in_a};
        head.flags.carry = raw[WIDTH];
`ifdef ARITH_SAT_EN
        head.flags.sat = raw[WIDTH];
        head.data      = !raw[WIDTH] ? raw[WIDTH-1:0] : (op == OP_ADD ? '1 : '0);
`else
        head.flags.sat = 1'b0;
        head.data      = raw[WIDTH-1:0];
`endif
    end

    assign vld[0]      = in_valid;
    assign pl[0]       = head;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        arith_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .reset_l  (reset_l),
            .in_valid (vld[i]),
            .in_ready (rdy[i]),
            .in_data  (pl[i]),
            .out_valid(vld[i+1]),
            .out_ready(rdy[i+1]),
            .out_data (pl[i+1])
        );
    end

    assign tail      = pl[STAGES];
    assign out_valid = vld[STAGES];
    assign out_data  = tail.data;
    assign out_carry = tail.flags.carry;
    assign out_sat   = tail.flags.sat;

    always_comb begin
        hs             = out_valid && out_ready;
        result_count_d = result_count_q + CNT_W'(hs);
        err_count_d    = (hs && out_carry && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            result_count_q <= '0;
            err_count_q    <= '0;
        end else begin
            result_count_q <= result_count_d;
            err_count_q    <= err_count_d;
        end
    end

    assign result_count = result_count_q;
    assign err_count    = err_count_q;

endmodule
